usb_packet_responder: RTL

Device-side packet responder on the byte interfaces of the USB serial interface engine. It consumes the decoded receive byte stream (PID + payload + CRC bytes), decodes token and data packets addressed to this device, tracks per-endpoint data toggles, and answers each transaction with a handshake packet (ACK/NAK/STALL) on the transmit byte interface. It sits between usb_rx/usb_tx and the endpoint backend, which receives one completion pulse per accepted OUT/SETUP data packet.

---
 rtl/usb_packet_pkg.sv | 51 +++++
 rtl/usb_toggle_bank.sv | 25 ++
 rtl/usb_packet_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/usb_packet_pkg.sv
// usb_packet_pkg: PID codes, responder FSM states and packet field helpers
// shared by the USB packet responder and its sub-blocks.
package usb_packet_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'h1,
        PID_IN    = 4'h9,
        PID_SOF   = 4'h5,
        PID_SETUP = 4'hD,
        PID_DATA0 = 4'h3,
        PID_DATA1 = 4'hB,
        PID_ACK   = 4'h2,
        PID_NAK   = 4'hA,
        PID_STALL = 4'hE
    } pid_e;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TOKEN1    = 3'd1;
    localparam logic [2:0] ST_TOKEN2    = 3'd2;
    localparam logic [2:0] ST_WAIT_DATA = 3'd3;
    localparam logic [2:0] ST_RX_DATA   = 3'd4;
    localparam logic [2:0] ST_DROP      = 3'd5;
    localparam logic [2:0] ST_TX_REQ    = 3'd6;
    localparam logic [2:0] ST_TX_WAIT   = 3'd7;

    function automatic logic [7:0] pid_byte(input pid_e p);
        return {~p, p};
    endfunction

    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic logic is_token(input logic [3:0] p);
        return p == PID_OUT || p == PID_IN || p == PID_SETUP;
    endfunction

    function automatic logic is_data(input logic [3:0] p);
        return p == PID_DATA0 || p == PID_DATA1;
    endfunction

    function automatic logic [6:0] tok_addr(input logic [7:0] b1);
        return b1[6:0];
    endfunction

    // Endpoint straddles the two token bytes: LSB is byte1[7], upper bits byte2[2:0].
    function automatic logic [3:0] tok_endp(input logic b1_msb, input logic [2:0] b2_lo);
        return {b2_lo, b1_msb};
    endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// usb_toggle_bank: per-endpoint DATA0/DATA1 toggle bits with set, flip and
// clear-all controls and a combinational read of the addressed endpoint.
module usb_toggle_bank (
    input  logic       i_clk48,
    input  logic       i_clear,
    input  logic       i_set,
    input  logic       i_flip,
    input  logic [3:0] i_ep,
    output logic       o_toggle
);

    logic [15:0] r_bits;

    assign o_toggle = r_bits[i_ep];

    always_ff @(posedge i_clk48) begin
        if (i_clear)
            r_bits <= '0;
        else if (i_set)
            r_bits[i_ep] <= 1'b1;
        else if (i_flip)
            r_bits[i_ep] <= ~r_bits[i_ep];
    end

endmodule

// File: rtl/usb_packet_responder.sv
// usb_packet_responder: decodes token/data packets for this device, tracks data
// toggles and answers each transaction with an ACK/NAK/STALL handshake.
module usb_packet_responder
    import usb_packet_pkg::*;
#(
    parameter logic [15:0] EP_MASK        = 16'h0003,
    parameter int          TIMEOUT_CYCLES = 128
) (
    input  logic        i_clk48,
    input  logic        i_rst,
    input  logic        i_usbResetDetect,
    input  logic [6:0]  i_deviceAddr,
    output logic        o_rxAcceptNewData,
    input  logic        i_rxDataValid,
    input  logic [7:0]  i_rxData,
    input  logic        i_rxIsLastByte,
    input  logic        i_keepPacket,
    output logic        o_reqSendPacket,
    output logic        o_sendDataValid,
    output logic [7:0]  o_sendData,
    output logic        o_lastData,
    input  logic        i_acceptNewData,
    input  logic        i_sending,
    output logic        o_pktDoneValid,
    output logic        o_pktIsSetup,
    output logic [3:0]  o_pktEndp,
    output logic [10:0] o_pktLen
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    logic [2:0]    r_state;
    logic [3:0]    r_tok_pid;
    logic [7:0]    r_tok1;
    logic [3:0]    r_endp;
    logic          r_is_setup;
    logic          r_data1;
    logic [10:0]   r_cnt;
    logic          r_ovf;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_tx_pid;
    logic          r_seen;

    logic          w_rst;
    logic          w_fire;
    logic          w_tog;
    logic          w_cnt_sat;
    logic [10:0]   w_cnt_nxt;
    logic          w_ovf_nxt;
    logic          w_ep_en;
    logic          w_rx_last;
    logic          w_rx_good;
    logic          w_done;
    logic [7:0]    w_resp;
    logic [3:0]    w_tok_ep;
    logic          w_tok_hit;

    assign w_rst     = i_rst | i_usbResetDetect;
    assign o_rxAcceptNewData = 1'b1;
    assign w_fire    = i_rxDataValid & o_rxAcceptNewData;
    assign w_cnt_sat = r_cnt == 11'h7FF;
    assign w_cnt_nxt = w_cnt_sat ? r_cnt : r_cnt + 11'd1;
    assign w_ovf_nxt = r_ovf | w_cnt_sat;
    assign w_ep_en   = EP_MASK[r_endp];
    assign w_rx_last = w_fire & i_rxIsLastByte & (r_state == ST_RX_DATA);
    assign w_rx_good = i_keepPacket & (w_cnt_nxt >= 11'd2) & ~w_ovf_nxt;
    // SETUP always needs DATA0; OUT completes only when the data PID matches the toggle.
    assign w_done    = w_rx_last & w_rx_good & w_ep_en &
                       (r_is_setup ? ~r_data1 : (r_data1 == w_tog));
    assign w_resp    = (!w_ep_en || (r_is_setup && r_data1)) ? pid_byte(PID_STALL) : pid_byte(PID_ACK);
    assign w_tok_ep  = tok_endp(r_tok1[7], i_rxData[2:0]);
    assign w_tok_hit = tok_addr(r_tok1) == i_deviceAddr;

    assign o_reqSendPacket = r_state == ST_TX_REQ;
    assign o_sendDataValid = r_state == ST_TX_REQ;
    assign o_lastData      = r_state == ST_TX_REQ;
    assign o_sendData      = (r_state == ST_TX_REQ) ? r_tx_pid : 8'h00;

    usb_toggle_bank u_toggles (
        .i_clk48  (i_clk48),
        .i_clear  (w_rst),
        .i_set    (w_done & r_is_setup),
        .i_flip   (w_done & ~r_is_setup),
        .i_ep     (r_endp),
        .o_toggle (w_tog)
    );

    always_ff @(posedge i_clk48) begin
        if (w_rst) begin
            r_state        <= ST_IDLE;
            r_tok_pid      <= '0;
            r_tok1         <= '0;
            r_endp         <= '0;
            r_is_setup     <= 1'b0;
            r_data1        <= 1'b0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_timer        <= '0;
            r_tx_pid       <= '0;
            r_seen         <= 1'b0;
            o_pktDoneValid <= 1'b0;
            o_pktIsSetup   <= 1'b0;
            o_pktEndp      <= '0;
            o_pktLen       <= '0;
        end else begin
            o_pktDoneValid <= w_done;
            if (w_done) begin
                o_pktLen     <= w_cnt_nxt - 11'd2;
                o_pktEndp    <= r_endp;
                o_pktIsSetup <= r_is_setup;
            end
            case (r_state)
                ST_IDLE: if (w_fire && !i_rxIsLastByte) begin
                    r_tok_pid <= i_rxData[3:0];
                    r_state   <= (pid_ok(i_rxData) && is_token(i_rxData[3:0])) ? ST_TOKEN1 : ST_DROP;
                end
                ST_TOKEN1: if (w_fire) begin
                    r_tok1  <= i_rxData;
                    r_state <= i_rxIsLastByte ? ST_IDLE : ST_TOKEN2;
                end
                ST_TOKEN2: if (w_fire) begin
                    r_endp     <= w_tok_ep;
                    r_is_setup <= r_tok_pid == PID_SETUP;
                    r_timer    <= '0;
                    r_tx_pid   <= EP_MASK[w_tok_ep] ? pid_byte(PID_NAK) : pid_byte(PID_STALL);
                    r_state    <= !i_rxIsLastByte ? ST_DROP :
                                  (!i_keepPacket || !w_tok_hit) ? ST_IDLE :
                                  (r_tok_pid == PID_IN) ? ST_TX_REQ : ST_WAIT_DATA;
                end
                ST_WAIT_DATA: if (w_fire) begin
                    r_data1 <= i_rxData[3:0] == PID_DATA1;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= i_rxIsLastByte ? ST_IDLE :
                               (pid_ok(i_rxData) && is_data(i_rxData[3:0])) ? ST_RX_DATA : ST_DROP;
                end else if (r_timer == TMO) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
                ST_RX_DATA: if (w_fire) begin
                    r_cnt <= w_cnt_nxt;
                    r_ovf <= w_ovf_nxt;
                    if (i_rxIsLastByte) begin
                        r_tx_pid <= w_resp;
                        r_state  <= w_rx_good ? ST_TX_REQ : ST_IDLE;
                    end
                end
                ST_DROP: if (w_fire && i_rxIsLastByte) r_state <= ST_IDLE;
                ST_TX_REQ: if (i_acceptNewData) begin
                    r_seen  <= 1'b0;
                    r_state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: if (i_sending) r_seen <= 1'b1;
                    else if (r_seen) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
